// File: rtl/breakout_game_ctrl.sv
// Game sequencing for the breakout display: ball count, saturating BCD score,
// frame-paced serve/over pauses and the freeze control for the graphics generator.
module breakout_game_ctrl #(
  parameter int BALLS        = 3,
  parameter int DELAY_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       hit,
  input  logic       miss,
  input  logic       brick_hit,
  input  logic       all_clear,
  output logic       gra_still,
  output logic [2:0] ball_cnt,
  output logic [15:0] score,
  output logic [1:0] text_sel,
  output logic       win,
  output logic       timer_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NEWBALL = 2'd1,
    PLAY    = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [2:0] BALLS_L = 3'(BALLS);
  localparam logic [7:0] DELAY_L = 8'(DELAY_FRAMES);

  // Digit-wise BCD add; a carry out of the thousands digit pins the result at 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] val, input logic [1:0] inc);
    logic [15:0] sum;
    logic [4:0]  d;
    logic [1:0]  carry;
    sum   = val;
    carry = inc;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, val[4*i +: 4]} + {3'b000, carry};
      if (d > 5'd9) begin
        sum[4*i +: 4] = 4'(d - 5'd10);
        carry         = 2'd1;
      end else begin
        sum[4*i +: 4] = d[3:0];
        carry         = 2'd0;
      end
    end
    if (carry != 2'd0) begin
      bcd_add_sat = 16'h9999;
    end else begin
      bcd_add_sat = sum;
    end
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  timer_r;
  logic [7:0]  timer_nxt_s;
  logic        hit_d_r;
  logic        brick_d_r;
  logic        hit_rise_s;
  logic        brick_rise_s;
  logic        refr_tick_s;
  logic        load_s;
  logic [2:0]  ball_nxt_s;
  logic        win_nxt_s;
  logic [15:0] score_nxt_s;
  logic        still_nxt_s;
  logic [1:0]  text_nxt_s;

  assign hit_rise_s   = hit & ~hit_d_r;
  assign brick_rise_s = brick_hit & ~brick_d_r;
  assign refr_tick_s  = (pix_y == 10'd481) && (pix_x == 10'd0);

  // Next state, game data and delay timer; outputs are decoded from the next state
  // so they register in step with it.
  always_comb begin
    state_nxt_s = state_r;
    ball_nxt_s  = ball_cnt;
    win_nxt_s   = win;
    score_nxt_s = score;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (btn != 5'd0) begin
          state_nxt_s = PLAY;
          score_nxt_s = 16'h0000;
          ball_nxt_s  = BALLS_L;
          win_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PLAY: begin
        score_nxt_s = bcd_add_sat(score, {1'b0, hit_rise_s} + {1'b0, brick_rise_s});
        if (all_clear) begin
          state_nxt_s = OVER;
          win_nxt_s   = 1'b1;
          load_s      = 1'b1;
        end else if (miss && (ball_cnt == 3'd1)) begin
          state_nxt_s = OVER;
          ball_nxt_s  = 3'd0;
          win_nxt_s   = 1'b0;
          load_s      = 1'b1;
        end else if (miss) begin
          state_nxt_s = NEWBALL;
          ball_nxt_s  = ball_cnt - 3'd1;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = PLAY;
        end
      end
      NEWBALL: begin
        if ((timer_r == 8'd0) && (btn != 5'd0)) begin
          state_nxt_s = PLAY;
        end else begin
          state_nxt_s = NEWBALL;
        end
      end
      OVER: begin
        if (timer_r == 8'd0) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OVER;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // A load in the same cycle as a frame tick takes precedence.
    if (load_s) begin
      timer_nxt_s = DELAY_L;
    end else if (refr_tick_s && (timer_r != 8'd0)) begin
      timer_nxt_s = timer_r - 8'd1;
    end else begin
      timer_nxt_s = timer_r;
    end

    case (state_nxt_s)
      IDLE:    begin still_nxt_s = 1'b1; text_nxt_s = 2'd0; end
      NEWBALL: begin still_nxt_s = 1'b1; text_nxt_s = 2'd1; end
      PLAY:    begin still_nxt_s = 1'b0; text_nxt_s = 2'd2; end
      OVER:    begin still_nxt_s = 1'b1; text_nxt_s = 2'd3; end
      default: begin still_nxt_s = 1'b1; text_nxt_s = 2'd0; end
    endcase
  end

  // State, data and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      timer_r    <= 8'd0;
      hit_d_r    <= 1'b0;
      brick_d_r  <= 1'b0;
      gra_still  <= 1'b1;
      text_sel   <= 2'd0;
      ball_cnt   <= BALLS_L;
      score      <= 16'h0000;
      win        <= 1'b0;
      timer_busy <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      timer_r    <= timer_nxt_s;
      hit_d_r    <= hit;
      brick_d_r  <= brick_hit;
      gra_still  <= still_nxt_s;
      text_sel   <= text_nxt_s;
      ball_cnt   <= ball_nxt_s;
      score      <= score_nxt_s;
      win        <= win_nxt_s;
      timer_busy <= (timer_nxt_s != 8'd0);
    end
  end

endmodule

// File: doc/breakout_game_ctrl.md
# breakout_game_ctrl

Game-sequencing controller for the breakout/pong display pipeline. It sits beside the graphics generator and drives its `gra_still` freeze input. It consumes the generator's `hit`/`miss` flags plus a brick-hit and all-cleared flag from the brick field. It tracks remaining balls and a 4-digit BCD score, and paces restart/over delays in video frames.

## Interface
- `BALLS`, default 3: balls per game, legal range 1..7.
- `DELAY_FRAMES`, default 120: frame ticks of pause in NEWBALL and OVER (2 s at 60 Hz), legal range 1..255.
- `clk` in 1: system/pixel clock.
- `reset` in 1: asynchronous, active-high.
- `btn` in 5: player buttons. Any nonzero value means "start/serve".
- `pix_x`, `pix_y` in 10 each: current scan position.
- `hit` in 1: paddle-hit level flag. Stays high for up to a whole frame.
- `miss` in 1: ball-past-border level flag.
- `brick_hit` in 1: brick-collision level flag.
- `all_clear` in 1: no bricks remain, level.
- `gra_still` out 1: freezes and re-centres ball and paddle.
- `ball_cnt` out 3: balls remaining.
- `score` out 16: BCD digits [15:12] thousands down to [3:0] units.
- `text_sel` out 2: 0 = press-start, 1 = serve-ready, 2 = playing, 3 = game over.
- `win` out 1: last game ended by clearing the field.
- `timer_busy` out 1: delay timer nonzero.

## Operation
- `refr_tick` is internal: it is 1 for exactly one clock when `pix_y == 481` and `pix_x == 0`.
- Edge detect: registered copies `hit_d` and `brick_d`.
  - `hit_rise = hit & ~hit_d`; `brick_rise = brick_hit & ~brick_d`.
  - These are the only events that change the score.
- State machine, states IDLE, NEWBALL, PLAY, OVER. State is a registered Moore machine; outputs decode from state.
- IDLE: `gra_still = 1`, `text_sel = 0`.
  - `btn != 0` → PLAY.
  - On that transition: score ← 0000, `ball_cnt` ← BALLS, `win` ← 0.
- PLAY: `gra_still = 0`, `text_sel = 2`. Priority order:
  1. `all_clear` → OVER, `win` ← 1, timer ← DELAY_FRAMES.
  2. `miss` and `ball_cnt == 1` → OVER, `ball_cnt` ← 0, `win` ← 0, timer ← DELAY_FRAMES.
  3. `miss` and `ball_cnt > 1` → NEWBALL, `ball_cnt` ← `ball_cnt` − 1, timer ← DELAY_FRAMES.
- NEWBALL: `gra_still = 1`, `text_sel = 1`.
  - `timer == 0` and `btn != 0` → PLAY.
  - Buttons are ignored while `timer_busy`.
- OVER: `gra_still = 1`, `text_sel = 3`.
  - `timer == 0` → IDLE.
  - `score`, `ball_cnt` and `win` hold for display.
- Timer: 8-bit down-counter.
  - Loaded on entry to NEWBALL or OVER.
  - Decrements by 1 on `refr_tick` while nonzero; never wraps below 0.
  - `timer_busy = (timer != 0)`.
- Score: updates only in PLAY, including the cycle a miss or all_clear transition is taken.
  - Increment = `hit_rise` + `brick_rise` (0, 1 or 2).
  - Addition is BCD with carry ripple across all four digits; no digit ever holds A–F.
  - Saturates at 9999: 9998 + 2 → 9999, and 9999 + 1 → 9999.
- Edge detectors run in every state. A flag already high when PLAY is entered does not count.

## Timing
- Reset values:
  - state IDLE, `gra_still` 1, `text_sel` 0;
  - `ball_cnt` BALLS, `score` 0x0000;
  - `win` 0, timer 0, `timer_busy` 0;
  - `hit_d` 0, `brick_d` 0.
- A mid-operation reset returns to these values immediately and asynchronously, including a reset with the timer running.
- Event → output latency is 1 clock. An input sampled high at edge n gives new state/outputs after edge n.
  - `miss` at edge n → `gra_still` high from n+1.
  - `hit` rising at edge n → score updated at n+1.
- Delay length: entering NEWBALL/OVER then takes exactly DELAY_FRAMES `refr_tick`s until `timer_busy` falls.
- A `refr_tick` in the load cycle does not decrement; the load wins.
- A held `miss` after re-entering PLAY causes no extra decrement. The generator clears `miss` while `gra_still` is high.
- `btn` held through OVER→IDLE: IDLE starts a new game on the next clock where `btn != 0`.

## Test plan
- Reset, then `btn = 5'h10` for 1 clk → next cycle PLAY, `gra_still = 0`, `ball_cnt = 3`, `score = 0x0000`, `text_sel = 2`.
- In PLAY, hold `hit` high 500 clks, drop it, then pulse `brick_hit` → score 0x0001 then 0x0002. Raise `hit` and `brick_hit` in the same clk → +2.
- Preload score 0x0099 via hits, then one hit → 0x0100. Drive to 0x9998 and raise both flags together → 0x9999. Another hit → 0x9999.
- With `ball_cnt = 3`, assert `miss`:
  - → NEWBALL, `ball_cnt = 2`, `timer_busy = 1`.
  - `btn` ignored for 119 ticks; after tick 120 `btn` → PLAY.
  - Repeat until the last miss → OVER, `ball_cnt = 0`; after 120 ticks → IDLE.
- Assert `miss` and `all_clear` in the same clk with `ball_cnt = 1` → OVER, `win = 1`, `ball_cnt = 1`.
- Assert `reset` 50 ticks into an OVER delay → all outputs at reset values asynchronously, state IDLE, `timer_busy = 0`.
